// File: rtl/skid_buffer_arbiter_rr.sv
// rtl/skid_buffer_arbiter_rr.sv - round-robin packet-locking arbiter feeding a 2-entry skid buffer
module skid_buffer_arbiter_rr #(
   parameter int WORD_WIDTH = 36,
   parameter int PORT_COUNT = 4,
   localparam int IW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic [PORT_COUNT-1:0]            s_valid,
   output logic [PORT_COUNT-1:0]            s_ready,
   input  logic [PORT_COUNT*WORD_WIDTH-1:0] s_data,
   input  logic [PORT_COUNT-1:0]            s_last,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [WORD_WIDTH-1:0]            m_data,
   output logic                             m_last,
   output logic [IW-1:0]                    m_source
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                state, state_next;
   logic [IW-1:0]         lock_id, lock_next;
   logic [IW-1:0]         ptr, ptr_next;

   logic [1:0]            count, count_next;
   logic                  space;

   logic [IW-1:0]         grant;
   logic                  grant_valid;
   logic [IW-1:0]         sel;
   logic                  sel_active;

   logic [WORD_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  push, pop;

   logic [WORD_WIDTH-1:0] head_data, skid_data;
   logic                  head_last, skid_last;
   logic [IW-1:0]         head_src,  skid_src;

   function automatic logic [IW-1:0] next_port(input logic [IW-1:0] p);
      return IW'((int'(p) + 1) % PORT_COUNT);
   endfunction

   // Round-robin scan: first valid port starting at ptr, wrapping at the last port.
   always_comb begin
      logic [IW-1:0] idx;
      idx         = '0;
      grant       = '0;
      grant_valid = 1'b0;
      for (int k = 0; k < PORT_COUNT; k++) begin
         idx = IW'((int'(ptr) + k) % PORT_COUNT);
         if (!grant_valid && s_valid[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
         end
      end
   end

   // Selected port is the packet owner while locked, otherwise the scan winner.
   always_comb begin
      sel        = (state == LOCKED) ? lock_id : grant;
      sel_active = (state == LOCKED) | grant_valid;
   end

   // Only the selected port sees ready, gated by registered space and held low in reset.
   always_comb begin
      s_ready = '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         if (sel == IW'(i)) begin
            s_ready[i] = reset_n & space & sel_active;
         end
      end
   end

   // Word and last flag of the selected port.
   always_comb begin
      in_data = '0;
      in_last = 1'b0;
      for (int i = 0; i < PORT_COUNT; i++) begin
         if (sel == IW'(i)) begin
            in_data = s_data[i*WORD_WIDTH +: WORD_WIDTH];
            in_last = s_last[i];
         end
      end
   end

   assign push     = |(s_valid & s_ready);
   assign m_valid  = (count != 2'd0);
   assign pop      = m_valid & m_ready;
   assign m_data   = head_data;
   assign m_last   = head_last;
   assign m_source = head_src;

   // Arbitration next state: lock on a non-final word, release and advance ptr on the final one.
   always_comb begin
      state_next = state;
      lock_next  = lock_id;
      ptr_next   = ptr;
      if (push) begin
         if (state == IDLE) begin
            if (in_last) begin
               ptr_next = next_port(grant);
            end else begin
               state_next = LOCKED;
               lock_next  = grant;
            end
         end else if (in_last) begin
            state_next = IDLE;
            ptr_next   = next_port(lock_id);
         end
      end
   end

   // Arbitration state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         lock_id <= '0;
         ptr     <= '0;
      end else begin
         state   <= state_next;
         lock_id <= lock_next;
         ptr     <= ptr_next;
      end
   end

   // Buffer occupancy after this cycle's push/pop.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   // Head/skid storage: head always holds the oldest word, skid catches the second.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count     <= 2'd0;
         space     <= 1'b1;
         head_data <= '0;
         head_last <= 1'b0;
         head_src  <= '0;
         skid_data <= '0;
         skid_last <= 1'b0;
         skid_src  <= '0;
      end else begin
         if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
            head_data <= in_data;
            head_last <= in_last;
            head_src  <= sel;
         end
         if (push && (count == 2'd1) && !pop) begin
            skid_data <= in_data;
            skid_last <= in_last;
            skid_src  <= sel;
         end
         if (pop && (count == 2'd2)) begin
            head_data <= skid_data;
            head_last <= skid_last;
            head_src  <= skid_src;
         end
         count <= count_next;
         space <= (count_next != 2'd2);
      end
   end

endmodule

// File: tb/tb_skid_buffer_arbiter_rr.sv
// tb/tb_skid_buffer_arbiter_rr.sv - scoreboard bench for skid_buffer_arbiter_rr, 4-port and 1-port
`timescale 1ns/1ps
module tb_skid_buffer_arbiter_rr;

   localparam int WW = 36;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fails  = 0;
   bit done4    = 1'b0;
   bit done1    = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   for (genvar c = 0; c < 2; c++) begin : g_cfg
      localparam int P   = (c == 0) ? 4 : 1;
      localparam int IWL = (P > 1) ? $clog2(P) : 1;

      logic                rst_n   = 1'b0;
      logic [P-1:0]        s_valid = '0;
      logic [P-1:0]        s_ready;
      logic [P*WW-1:0]     s_data  = '0;
      logic [P-1:0]        s_last  = '0;
      logic                m_valid;
      logic                m_ready = 1'b0;
      logic [WW-1:0]       m_data;
      logic                m_last;
      logic [IWL-1:0]      m_source;

      logic [63:0]         sb[$];
      int                  seq [P];
      int                  acc [P];
      int                  owner     = -1;
      int                  ptr       = 0;
      int                  out_owner = -1;

      skid_buffer_arbiter_rr #(.WORD_WIDTH(WW), .PORT_COUNT(P)) dut (
         .clock    (clock),
         .reset_n  (rst_n),
         .s_valid  (s_valid),
         .s_ready  (s_ready),
         .s_data   (s_data),
         .s_last   (s_last),
         .m_valid  (m_valid),
         .m_ready  (m_ready),
         .m_data   (m_data),
         .m_last   (m_last),
         .m_source (m_source)
      );

      initial begin
         for (int i = 0; i < P; i++) begin
            seq[i] = 0;
            acc[i] = 0;
         end
      end

      // Each port's word carries its index and a per-port sequence number.
      always @(posedge clock) begin
         #1;
         for (int i = 0; i < P; i++) s_data[i*WW +: WW] = {4'(i), 32'(seq[i])};
      end

      // Input side: predict ready from the arbitration rules, record accepted words.
      always @(negedge clock) begin : in_side
         int           g;
         logic [P-1:0] exp_ready;
         if (!rst_n) begin
            sb.delete();
            owner     = -1;
            ptr       = 0;
            out_owner = -1;
            chk(s_ready == '0, "ready_in_reset", 64'(s_ready), 64'(0));
            chk(m_valid == 1'b0, "mvalid_in_reset", 64'(m_valid), 64'(0));
         end else begin
            g = -1;
            if (owner >= 0) g = owner;
            else for (int k = 0; k < P; k++)
               if (g < 0 && s_valid[(ptr + k) % P]) g = (ptr + k) % P;
            exp_ready = '0;
            if (g >= 0 && sb.size() < 2) exp_ready[g] = 1'b1;
            chk(s_ready == exp_ready, "s_ready", 64'(s_ready), 64'(exp_ready));
            chk(m_valid == (sb.size() != 0), "m_valid", 64'(m_valid), 64'(sb.size() != 0));
            for (int i = 0; i < P; i++) begin
               if (s_valid[i] && s_ready[i]) begin
                  sb.push_back({20'(i), 8'(s_last[i]), s_data[i*WW +: WW]});
                  seq[i]++;
                  acc[i]++;
                  if (s_last[i]) begin
                     owner = -1;
                     ptr   = (i + 1) % P;
                  end else begin
                     owner = i;
                  end
               end
            end
         end
      end

      // Output side: compare the presented word with the oldest outstanding one.
      always @(negedge clock) begin : out_side
         logic [63:0] e;
         #1;
         if (rst_n && m_valid) begin
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_word", 64'(m_data), 64'(0));
            end else begin
               e = sb[0];
               chk(m_data == e[35:0], "m_data", 64'(m_data), 64'(e[35:0]));
               chk(m_last == e[36], "m_last", 64'(m_last), 64'(e[36]));
               chk(m_source == IWL'(e[63:44]), "m_source", 64'(m_source), 64'(e[63:44]));
               if (m_ready) begin
                  if (out_owner >= 0)
                     chk(int'(m_source) == out_owner, "interleave", 64'(m_source), 64'(out_owner));
                  out_owner = m_last ? -1 : int'(m_source);
                  void'(sb.pop_front());
               end
            end
         end
      end

      task automatic random_phase(input int cycles);
         for (int n = 0; n < cycles; n++) begin
            for (int i = 0; i < P; i++) begin
               s_valid[i] = ($urandom_range(0, 3) != 0);
               s_last[i]  = ($urandom_range(0, 2) == 0);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            step();
         end
         s_valid = '0;
         m_ready = 1'b1;
         repeat (6) step();
         chk(sb.size() == 0, "drained", 64'(sb.size()), 64'(0));
         chk(m_valid == 1'b0, "idle_after_drain", 64'(m_valid), 64'(0));
      endtask

      if (P == 4) begin : g_drv
         int exp_src [5] = '{2, 2, 2, 3, 0};
         int exp_lst [5] = '{0, 0, 1, 1, 1};
         initial begin
            int a0;
            // Reset with every port requesting, then single-word round robin.
            rst_n = 1'b0; s_valid = '1; s_last = '1; m_ready = 1'b0;
            repeat (2) step();
            rst_n = 1'b1; m_ready = 1'b1;
            for (int k = 1; k <= 8; k++) begin
               step();
               chk(m_valid && (int'(m_source) == (k - 1) % 4), "rr_order", 64'(m_source), 64'((k - 1) % 4));
            end
            s_valid = '0;
            repeat (2) step();
            // Port 1 alone moves the pointer to 2, then port 2 sends a 3-word packet.
            s_valid = 4'b0010;
            step();
            s_valid = 4'b1101; s_last = 4'b1011;
            for (int k = 0; k < 5; k++) begin
               if (k == 2) s_last = 4'b1111;
               step();
               chk(int'(m_source) == exp_src[k], "pkt_source", 64'(m_source), 64'(exp_src[k]));
               chk(int'(m_last) == exp_lst[k], "pkt_last", 64'(m_last), 64'(exp_lst[k]));
            end
            s_valid = '0;
            repeat (3) step();
            // Backpressure: exactly two words fit, ready returns one cycle after drain starts.
            m_ready = 1'b0; s_valid = 4'b0010; a0 = acc[1];
            repeat (4) step();
            chk(acc[1] - a0 == 2, "bp_accepted", 64'(acc[1] - a0), 64'(2));
            chk(s_ready[1] == 1'b0, "bp_ready_low", 64'(s_ready[1]), 64'(0));
            m_ready = 1'b1;
            step();
            chk(s_ready[1] == 1'b1, "bp_ready_back", 64'(s_ready[1]), 64'(1));
            s_valid = '0;
            repeat (4) step();
            // Locked owner pauses mid-packet while port 1 waits.
            s_valid = 4'b0001; s_last = 4'b1110;
            step();
            s_valid = 4'b0010;
            for (int k = 0; k < 5; k++) begin
               step();
               chk(s_ready[1] == 1'b0, "lock_hold", 64'(s_ready[1]), 64'(0));
            end
            s_valid = 4'b0011; s_last = 4'b1111;
            step();
            step();
            chk(int'(m_source) == 1, "after_lock", 64'(m_source), 64'(1));
            s_valid = '0;
            repeat (3) step();
            // Asynchronous reset with a full buffer mid-packet.
            m_ready = 1'b0; s_valid = 4'b0001; s_last = 4'b0000;
            repeat (3) step();
            chk(m_valid == 1'b1, "full_valid", 64'(m_valid), 64'(1));
            chk(s_ready == 4'b0000, "full_ready", 64'(s_ready), 64'(0));
            #2; rst_n = 1'b0; #1;
            chk(m_valid == 1'b0, "async_reset", 64'(m_valid), 64'(0));
            chk(s_ready == 4'b0000, "async_ready", 64'(s_ready), 64'(0));
            repeat (2) step();
            rst_n = 1'b1; s_valid = '1; s_last = '1; m_ready = 1'b1;
            step();
            chk(m_valid && m_source == 2'd0, "post_reset_grant", 64'(m_source), 64'(0));
            s_valid = '0;
            repeat (3) step();
            random_phase(10000);
            done4 = 1'b1;
         end
      end else begin : g_drv
         initial begin
            rst_n = 1'b0; s_valid = '1; s_last = '1; m_ready = 1'b0;
            repeat (2) step();
            rst_n = 1'b1;
            random_phase(10000);
            done1 = 1'b1;
         end
      end
   end

   initial begin
      int t;
      t = 0;
      while (!(done4 && done1) && t < 40000) begin
         @(posedge clock);
         t++;
      end
      chk(done4 && done1, "timeout", 64'({done4, done1}), 64'(3));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
